// File: rtl/ccr_pkg.sv
// ---------------------------------------------------------------------------
// ccr_pkg
// Shared definitions for the condition-code register controller:
//   - flag bit indices inside the 3-bit CCR ({C,N,Z})
//   - the flags typedef
//   - the shadow-stack state enum and a helper mapping occupancy to state
// Optional feature macro used by ccr_ctrl: CCR_JUMP_CLEAR_EN
// ---------------------------------------------------------------------------
package ccr_pkg;

   localparam int CCR_Z = 0;
   localparam int CCR_N = 1;
   localparam int CCR_C = 2;

   typedef logic [2:0] ccr_flags_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } stack_state_e;

   // Stack state is a pure function of occupancy: 0 -> EMPTY,
   // max -> FULL, anything in between -> PARTIAL.
   function automatic stack_state_e depth_to_state(input logic [2:0] d,
                                                   input logic [2:0] max_d);
      if (d == 3'd0) begin
         return EMPTY;
      end else if (d >= max_d) begin
         return FULL;
      end else begin
         return PARTIAL;
      end
   endfunction

endpackage

// File: rtl/ccr_shadow_stack.sv
// ---------------------------------------------------------------------------
// ccr_shadow_stack
// LIFO of CCR snapshots for nested interrupts, with occupancy counter and
// sticky overflow/underflow errors.
//
// Ports
//   clk, rst_n    : clock, asynchronous active-low reset
//   en_i          : update enable (low freezes depth, errors and storage)
//   push_i        : push push_data_i (ignored when pop_i is also high)
//   pop_i         : pop the top snapshot onto pop_data_o
//   push_data_i   : snapshot to store
//   pop_data_o    : snapshot at index depth-1 (valid while pop_ok_o is high)
//   pop_ok_o      : a pop is being accepted on this edge
//   depth_o       : current occupancy, 0..SHADOW_DEPTH
//   ovf_err_o     : sticky, push attempted while FULL
//   unf_err_o     : sticky, pop attempted while EMPTY
//   state_o       : stack FSM state (debug)
//
// Strobe semantics: push_i/pop_i are single-cycle requests sampled on the
// posedge where en_i=1; there is no back-pressure, a request that cannot be
// served is dropped and recorded in the matching error flag.
// ---------------------------------------------------------------------------
module ccr_shadow_stack
   import ccr_pkg::*;
#(
   parameter int SHADOW_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  ccr_flags_t   push_data_i,
   output ccr_flags_t   pop_data_o,
   output logic         pop_ok_o,
   output logic [2:0]   depth_o,
   output logic         ovf_err_o,
   output logic         unf_err_o,
   output stack_state_e state_o
);

   localparam int         IDX_W     = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;
   localparam logic [2:0] DEPTH_MAX = 3'(SHADOW_DEPTH);

   stack_state_e     state_q, state_d;
   logic [2:0]       depth_q, depth_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   ccr_flags_t       mem_q [SHADOW_DEPTH];

   logic             is_full;
   logic             is_empty;
   logic             do_push;
   logic             do_pop;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] rd_idx;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         depth_q <= 3'd0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Next-state logic. Pop wins over push; depth saturates at both ends
   // instead of wrapping.
   always_comb begin
      depth_d = depth_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      if (en_i) begin
         if (pop_i) begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else begin
               depth_d = depth_q - 3'd1;
            end
         end else if (push_i) begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               depth_d = depth_q + 3'd1;
            end
         end
      end
      state_d = depth_to_state(depth_d, DEPTH_MAX);
   end

   // Output logic
   always_comb begin
      is_full   = (state_q == FULL);
      is_empty  = (state_q == EMPTY);
      do_push   = en_i & push_i & ~pop_i & ~is_full;
      do_pop    = en_i & pop_i & ~is_empty;
      wr_idx    = depth_q[IDX_W-1:0];
      rd_idx    = wr_idx - 1'b1;
      pop_ok_o  = do_pop;
      depth_o   = depth_q;
      ovf_err_o = ovf_q;
      unf_err_o = unf_q;
      state_o   = state_q;
   end

   assign pop_data_o = mem_q[rd_idx];

   // Snapshot storage needs no reset: a slot is only read after a push.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= push_data_i;
      end
   end

endmodule

// File: rtl/ccr_ctrl.sv
// ---------------------------------------------------------------------------
// ccr_ctrl
// Condition-code register {C,N,Z} with a single-winner update priority
// (rti_restore > int_save > flags_we > setc/clrc > jump clear), conditional
// jump evaluation, and a shadow stack for interrupt nesting.
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   alu_flags [2:0]   : {C,N,Z} from the ALU, loaded when flags_we=1
//   flags_we          : load alu_flags into the CCR
//   setc, clrc        : force C to 1 / 0 (both together: C unchanged)
//   jz, jn, jc        : conditional-jump evaluate strobes
//   int_save          : push CCR onto the shadow stack
//   rti_restore       : pop shadow stack into the CCR
//   stall             : freeze all state
//   ccr [2:0]         : registered CCR
//   jump_taken        : (jz&Z)|(jn&N)|(jc&C) from the registered CCR
//   depth [2:0]       : shadow stack occupancy
//   ovf_err, unf_err  : sticky push-when-full / pop-when-empty errors
//   stack_state       : shadow stack FSM state (debug)
//
// Build option: define CCR_JUMP_CLEAR_EN to clear the tested flag(s) when a
// jump is taken and no higher-priority action owns the cycle.
// ---------------------------------------------------------------------------
module ccr_ctrl
   import ccr_pkg::*;
#(
   parameter int SHADOW_DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [2:0]   alu_flags,
   input  logic         flags_we,
   input  logic         setc,
   input  logic         clrc,
   input  logic         jz,
   input  logic         jn,
   input  logic         jc,
   input  logic         int_save,
   input  logic         rti_restore,
   input  logic         stall,
   output logic [2:0]   ccr,
   output logic         jump_taken,
   output logic [2:0]   depth,
   output logic         ovf_err,
   output logic         unf_err,
   output stack_state_e stack_state
);

   ccr_flags_t ccr_q, ccr_d;
   ccr_flags_t pop_data;
   logic       pop_ok;

   ccr_shadow_stack #(
      .SHADOW_DEPTH (SHADOW_DEPTH)
   ) u_shadow (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (~stall),
      .push_i      (int_save),
      .pop_i       (rti_restore),
      .push_data_i (ccr_q),
      .pop_data_o  (pop_data),
      .pop_ok_o    (pop_ok),
      .depth_o     (depth),
      .ovf_err_o   (ovf_err),
      .unf_err_o   (unf_err),
      .state_o     (stack_state)
   );

   // Evaluated on the registered CCR only: a flags_we in the same cycle is
   // not forwarded.
   assign jump_taken = (jz & ccr_q[CCR_Z]) | (jn & ccr_q[CCR_N]) | (jc & ccr_q[CCR_C]);

   always_comb begin
      ccr_d = ccr_q;
      if (!stall) begin
         if (rti_restore) begin
            // Underflow leaves the CCR untouched.
            if (pop_ok) begin
               ccr_d = pop_data;
            end
         end else if (int_save) begin
            // Push only; the CCR keeps its value and blocks lower actions.
            ccr_d = ccr_q;
         end else if (flags_we) begin
            ccr_d = alu_flags;
         end else if (setc | clrc) begin
            // setc and clrc together cancel out but still own the cycle.
            if (setc ^ clrc) begin
               ccr_d[CCR_C] = setc;
            end
         end else begin
`ifdef CCR_JUMP_CLEAR_EN
            if (jump_taken) begin
               if (jz) ccr_d[CCR_Z] = 1'b0;
               if (jn) ccr_d[CCR_N] = 1'b0;
               if (jc) ccr_d[CCR_C] = 1'b0;
            end
`else
            ccr_d = ccr_q;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ccr_q <= 3'b000;
      end else begin
         ccr_q <= ccr_d;
      end
   end

   assign ccr = ccr_q;

endmodule

// File: tb/tb_ccr_ctrl.sv
module tb_ccr_ctrl;
   import ccr_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]   alu_flags;
   logic         flags_we, setc, clrc, jz, jn, jc;
   logic         int_save, rti_restore, stall;
   logic [2:0]   ccr;
   logic         jump_taken;
   logic [2:0]   depth;
   logic         ovf_err, unf_err;
   stack_state_e stack_state;

   int n_checks = 0;
   int n_pass   = 0;

   ccr_ctrl #(.SHADOW_DEPTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_flags   (alu_flags),
      .flags_we    (flags_we),
      .setc        (setc),
      .clrc        (clrc),
      .jz          (jz),
      .jn          (jn),
      .jc          (jc),
      .int_save    (int_save),
      .rti_restore (rti_restore),
      .stall       (stall),
      .ccr         (ccr),
      .jump_taken  (jump_taken),
      .depth       (depth),
      .ovf_err     (ovf_err),
      .unf_err     (unf_err),
      .stack_state (stack_state)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      alu_flags = 3'b000; flags_we = 1'b0; setc = 1'b0; clrc = 1'b0;
      jz = 1'b0; jn = 1'b0; jc = 1'b0;
      int_save = 1'b0; rti_restore = 1'b0; stall = 1'b0;
   endtask

   // Advance one edge, then sample 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_flags(input logic [2:0] f);
      idle();
      flags_we = 1'b1; alu_flags = f;
      tick();
      idle();
   endtask

   task automatic do_save();
      idle(); int_save = 1'b1; tick(); idle();
   endtask

   task automatic do_restore();
      idle(); rti_restore = 1'b1; tick(); idle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [2:0] exp_jclr;
`ifdef CCR_JUMP_CLEAR_EN
      exp_jclr = 3'b000;
`else
      exp_jclr = 3'b001;
`endif
      idle();
      #12;
      check("rst_ccr",   {5'd0, ccr}, 8'h00);
      check("rst_depth", {5'd0, depth}, 8'h00);
      check("rst_ovf",   {7'd0, ovf_err}, 8'h00);
      check("rst_unf",   {7'd0, unf_err}, 8'h00);
      check("rst_state", {6'd0, stack_state}, {6'd0, EMPTY});
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // stalled write is dropped
      stall = 1'b1; flags_we = 1'b1; alu_flags = 3'b101;
      tick();
      check("stall_we", {5'd0, ccr}, 8'h00);

      // write with no bypass into jump_taken
      stall = 1'b0; jz = 1'b1;
      #1;
      check("no_bypass", {7'd0, jump_taken}, 8'h00);
      tick();
      check("we_101", {5'd0, ccr}, 8'h05);
      check("jz_on_101", {7'd0, jump_taken}, 8'h01);
      idle();

      // jump evaluation and optional clear
      load_flags(3'b001);
      check("we_001", {5'd0, ccr}, 8'h01);
      jz = 1'b1;
      #1;
      check("jz_taken", {7'd0, jump_taken}, 8'h01);
      tick();
      idle();
      check("jz_clear", {5'd0, ccr}, {5'd0, exp_jclr});
      load_flags(3'b001);
      jn = 1'b1; jc = 1'b1;
      #1;
      check("jn_jc_not_taken", {7'd0, jump_taken}, 8'h00);
      idle();

      // save / overwrite / restore
      load_flags(3'b110);
      do_save();
      check("save_depth1", {5'd0, depth}, 8'h01);
      check("save_ccr", {5'd0, ccr}, 8'h06);
      check("state_partial", {6'd0, stack_state}, {6'd0, PARTIAL});
      load_flags(3'b001);
      check("isr_ccr", {5'd0, ccr}, 8'h01);
      do_restore();
      check("rest_depth0", {5'd0, depth}, 8'h00);
      check("rest_ccr", {5'd0, ccr}, 8'h06);

      // overflow and LIFO order
      load_flags(3'b011); do_save();
      load_flags(3'b100); do_save();
      check("state_full", {6'd0, stack_state}, {6'd0, FULL});
      load_flags(3'b010); do_save();
      check("ovf_depth", {5'd0, depth}, 8'h02);
      check("ovf_err", {7'd0, ovf_err}, 8'h01);
      check("ovf_ccr", {5'd0, ccr}, 8'h02);
      do_restore();
      check("lifo_1", {5'd0, ccr}, 8'h04);
      check("lifo_1_depth", {5'd0, depth}, 8'h01);
      do_restore();
      check("lifo_2", {5'd0, ccr}, 8'h03);
      check("lifo_unf_clean", {7'd0, unf_err}, 8'h00);

      // underflow
      do_restore();
      check("unf_err", {7'd0, unf_err}, 8'h01);
      check("unf_ccr", {5'd0, ccr}, 8'h03);
      check("unf_depth", {5'd0, depth}, 8'h00);
      check("ovf_sticky", {7'd0, ovf_err}, 8'h01);

      // int_save + flags_we: push only
      int_save = 1'b1; flags_we = 1'b1; alu_flags = 3'b111;
      tick();
      idle();
      check("push_only_depth", {5'd0, depth}, 8'h01);
      check("push_only_ccr", {5'd0, ccr}, 8'h03);

      // stall freezes restore
      stall = 1'b1; rti_restore = 1'b1;
      tick();
      idle();
      check("stall_rest_depth", {5'd0, depth}, 8'h01);
      check("stall_rest_ccr", {5'd0, ccr}, 8'h03);

      // setc / clrc
      setc = 1'b1; clrc = 1'b1; tick(); idle();
      check("setclr_c0", {5'd0, ccr}, 8'h03);
      setc = 1'b1; tick(); idle();
      check("setc", {5'd0, ccr}, 8'h07);
      setc = 1'b1; clrc = 1'b1; tick(); idle();
      check("setclr_c1", {5'd0, ccr}, 8'h07);
      clrc = 1'b1; tick(); idle();
      check("clrc", {5'd0, ccr}, 8'h03);

      // setc/clrc outranks jump clear: ccr stays 011 after jz+setc+clrc
      jz = 1'b1; setc = 1'b1; clrc = 1'b1; tick(); idle();
      check("setclr_over_jump", {5'd0, ccr}, 8'h03);

      // asynchronous reset mid-cycle with depth=1
      check("pre_rst_depth", {5'd0, depth}, 8'h01);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_ccr", {5'd0, ccr}, 8'h00);
      check("async_depth", {5'd0, depth}, 8'h00);
      check("async_unf", {7'd0, unf_err}, 8'h00);
      check("async_ovf", {7'd0, ovf_err}, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      load_flags(3'b101);
      check("post_rst_we", {5'd0, ccr}, 8'h05);

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
